// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the front end of the pipeline: fetch FSM state
// encoding, datapath widths, the NOP encoding and the IF/ID register layout
// (the IF/ID struct is also consumed by the decode stage).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Instruction word used to fill IF/ID whenever it does not hold a real
    // instruction.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // FETCH: free to issue a request
    // WAIT : request granted, response still to come and will be delivered
    // DROP : request granted, response still to come but must be discarded
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction-memory response that arrived
// while IF/ID could not accept it.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous reset, active-low
//   clear_i      discard the entry (highest priority)
//   push_i       load {push_pc_i, push_instr_i}; wins over pop_i so that a
//                same-cycle pop+push replaces the entry
//   pop_i        release the entry
//   push_pc_i    address of the incoming instruction
//   push_instr_i incoming instruction word
//   valid_o      entry occupied
//   pc_o         stored address
//   instr_o      stored instruction word
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Next-entry selection: clear beats push, push beats pop.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            valid_d = 1'b1;
            pc_d    = push_pc_i;
            instr_d = push_instr_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= {ADDR_W{1'b0}};
            instr_q <= {INSTR_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the program counter, issues word fetches over
// a req/gnt/rvalid handshake with at most one request outstanding, and loads
// {pc, pc+4, instr} into the IF/ID register for decode. Stall holds IF/ID,
// flush discards IF/ID plus any in-flight fetch and redirects the PC. A
// one-entry skid buffer catches a response that lands while IF/ID is stalled.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  instruction value held in IF/ID while it is invalid
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous reset, active-low
//   imem_req       fetch request valid
//   imem_addr      fetch byte address (word aligned)
//   imem_gnt       request accepted this cycle
//   imem_rvalid    response valid
//   imem_rdata     response instruction word
//   stall          hold IF/ID contents
//   flush          discard IF/ID and in-flight fetch, redirect PC
//   redirect_pc    new fetch address, used only with flush
//   ifid_valid     IF/ID holds a real instruction
//   ifid_pc        address of ifid_instr
//   ifid_pc_plus4  ifid_pc + 4 (mod 2^32)
//   ifid_instr     fetched instruction or NOP_INSTR
//   bubble_count   (only with FETCH_PERF_EN) saturating count of cycles with
//                  an empty, unstalled IF/ID outside reset
//
// Build option: define FETCH_PERF_EN to add the bubble_count port/counter.
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic [INSTR_W-1:0] ifid_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        bubble_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    ifid_t             ifid_q,   ifid_d;

    logic               imem_req_s;
    logic               grant_s;
    logic               rsp_live_s;
    logic               accept_s;
    logic               skid_valid_s;
    logic [ADDR_W-1:0]  skid_pc_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic               skid_push_s;
    logic               skid_pop_s;
    logic               skid_clear_s;

    // Issue is blocked while the skid is occupied: the only place a response
    // could land is the skid, so this keeps it from ever being overwritten.
    assign imem_req_s = reset & (state_q == FETCH) & ~skid_valid_s & ~flush;
    assign grant_s    = imem_req_s & imem_gnt;
    // A response is only "live" (deliverable) in WAIT and when not flushed.
    assign rsp_live_s = (state_q == WAIT) & imem_rvalid & ~flush;
    assign accept_s   = ~ifid_q.valid | ~stall;

    // FSM next state and PC update; flush redirects regardless of state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (flush) begin
            pc_d = word_align(redirect_pc);
            case (state_q)
                FETCH:   state_d = FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DROP;
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (grant_s) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end else begin
                        state_d  = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end else begin
                        state_d = WAIT;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // IF/ID load and skid control: skid content is older than the live
    // response, so it is delivered first and the response takes its place.
    always_comb begin
        ifid_d       = ifid_q;
        skid_push_s  = 1'b0;
        skid_pop_s   = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            skid_clear_s = 1'b1;
        end else if (accept_s) begin
            if (skid_valid_s) begin
                ifid_d.valid    = 1'b1;
                ifid_d.pc       = skid_pc_s;
                ifid_d.pc_plus4 = skid_pc_s + 32'd4;
                ifid_d.instr    = skid_instr_s;
                skid_pop_s      = 1'b1;
                skid_push_s     = rsp_live_s;
            end else if (rsp_live_s) begin
                ifid_d.valid    = 1'b1;
                ifid_d.pc       = req_pc_q;
                ifid_d.pc_plus4 = req_pc_q + 32'd4;
                ifid_d.instr    = imem_rdata;
            end else begin
                // Bubble: pc fields deliberately keep their last value.
                ifid_d.valid    = 1'b0;
                ifid_d.instr    = NOP_INSTR;
            end
        end else begin
            skid_push_s = rsp_live_s;
        end
    end

    // Pipeline state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            req_pc_q        <= {ADDR_W{1'b0}};
            ifid_q.valid    <= 1'b0;
            ifid_q.pc       <= {ADDR_W{1'b0}};
            ifid_q.pc_plus4 <= {ADDR_W{1'b0}};
            ifid_q.instr    <= NOP_INSTR;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_pc_q        <= req_pc_d;
            ifid_q          <= ifid_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (skid_clear_s),
        .push_i       (skid_push_s),
        .pop_i        (skid_pop_s),
        .push_pc_i    (req_pc_q),
        .push_instr_i (imem_rdata),
        .valid_o      (skid_valid_s),
        .pc_o         (skid_pc_s),
        .instr_o      (skid_instr_s)
    );

    assign imem_req      = imem_req_s;
    assign imem_addr     = pc_q;
    assign ifid_valid    = ifid_q.valid;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_instr    = ifid_q.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q, bubble_d;

    // Bubble counter next value, saturating at all-ones.
    always_comb begin
        bubble_d = bubble_q;
        if (!ifid_q.valid && !stall && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end else begin
            bubble_d = bubble_q;
        end
    end

    // Bubble counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_q <= 32'd0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_count = bubble_q;
`else
    // Performance counter not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_V  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_count;
`endif

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP_V)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr)
`ifdef FETCH_PERF_EN
        ,
        .bubble_count  (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = 32'd0;
    int          mem_cnt     = 0;
    int          mem_lat     = 0;
    bit          lat_rand    = 1'b0;
    int          gnt_pct     = 100;

    // observations of the last stepped cycle
    logic        last_req;
    logic [31:0] last_addr;
    logic        last_gnt;

    // reference model: program-order pointers
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_exec  = RST_PC;
    logic [31:0] exp_bub   = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // One clock cycle: drive at negedge, observe before the edge, check after.
    task automatic step(input logic rst_v, input logic stall_v, input logic flush_v,
                        input logic [31:0] redir_v);
        logic        hold_chk;
        logic [31:0] h_pc, h_p4, h_in;
        reset       = rst_v;
        stall       = stall_v;
        flush       = flush_v;
        redirect_pc = redir_v;
        if (mem_pending && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        imem_gnt  = last_req && ($urandom_range(99) < gnt_pct);
        last_gnt  = imem_gnt;

        checks++;
        if (last_req === 1'b1 && (flush_v || !rst_v || mem_pending)) begin
            errors++;
            $display("FAIL req_gating: got imem_req=%b required 0 (flush=%b reset=%b outstanding=%b)",
                     last_req, flush_v, rst_v, mem_pending);
        end
        if (last_req === 1'b1 && last_gnt) begin
            checks++;
            if (last_addr !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr: got %h required %h", last_addr, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rst_v && ifid_valid === 1'b1 && !stall_v && !flush_v) begin
            checks++;
            if (ifid_pc !== exp_exec) begin
                errors++;
                $display("FAIL exec_pc: got %h required %h", ifid_pc, exp_exec);
            end
            checks++;
            if (ifid_instr !== mem_word(ifid_pc)) begin
                errors++;
                $display("FAIL exec_instr: got %h required %h", ifid_instr, mem_word(ifid_pc));
            end
            checks++;
            if (ifid_pc_plus4 !== ifid_pc + 32'd4) begin
                errors++;
                $display("FAIL exec_pc_plus4: got %h required %h", ifid_pc_plus4, ifid_pc + 32'd4);
            end
            exp_exec = ifid_pc + 32'd4;
        end
        hold_chk = rst_v && !flush_v && stall_v && (ifid_valid === 1'b1);
        h_pc = ifid_pc;
        h_p4 = ifid_pc_plus4;
        h_in = ifid_instr;
        if (rst_v && ifid_valid === 1'b0 && !stall_v && exp_bub != 32'hFFFF_FFFF)
            exp_bub = exp_bub + 32'd1;

        @(posedge clk);
        if (!rst_v) begin
            mem_pending = 1'b0;
        end else begin
            if (imem_rvalid) mem_pending = 1'b0;
            if (last_req && last_gnt) begin
                mem_pending = 1'b1;
                mem_addr    = last_addr;
                mem_cnt     = lat_rand ? $urandom_range(3) : mem_lat;
            end else if (mem_pending && mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        if (!rst_v) begin
            exp_fetch = RST_PC;
            exp_exec  = RST_PC;
            exp_bub   = 32'd0;
        end else if (flush_v) begin
            exp_fetch = {redir_v[31:2], 2'b00};
            exp_exec  = {redir_v[31:2], 2'b00};
        end
        #1;
        if (hold_chk) begin
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== h_pc || ifid_pc_plus4 !== h_p4 || ifid_instr !== h_in) begin
                errors++;
                $display("FAIL stall_hold: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                         ifid_valid, ifid_pc, ifid_instr, h_pc, h_in);
            end
        end
        if (!rst_v || flush_v) begin
            checks++;
            if (ifid_valid !== 1'b0 || ifid_instr !== NOP_V) begin
                errors++;
                $display("FAIL kill_ifid: got v=%b instr=%h required v=0 instr=%h",
                         ifid_valid, ifid_instr, NOP_V);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (bubble_count !== exp_bub) begin
            errors++;
            $display("FAIL bubble_count: got %0d required %0d", bubble_count, exp_bub);
        end
`endif
        @(negedge clk);
    endtask

    task automatic do_reset;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic wait_grant(input logic [31:0] a, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (last_req && last_gnt && last_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_grant_timeout: grant for %h not seen within %0d cycles", a, budget);
        end
    endtask

    task automatic test_reset;
        lat_rand = 1'b0; mem_lat = 0; gnt_pct = 100;
        do_reset();
        checks++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_pc_plus4 !== 32'd0 || ifid_instr !== NOP_V) begin
            errors++;
            $display("FAIL reset_ifid: got v=%b pc=%h p4=%h instr=%h required 0/0/0/%h",
                     ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, NOP_V);
        end
        checks++;
        if (last_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b required 0", last_req);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (last_req !== 1'b1 || last_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h required req=1 addr=%h",
                     last_req, last_addr, RST_PC);
        end
    endtask

    task automatic test_zero_latency;
        int          gcyc[$];
        logic [31:0] gaddr[$];
        logic [31:0] dpc[$];
        lat_rand = 1'b0; mem_lat = 0; gnt_pct = 100;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (last_req && last_gnt) begin
                gcyc.push_back(c);
                gaddr.push_back(last_addr);
            end
            if (ifid_valid === 1'b1) dpc.push_back(ifid_pc);
        end
        checks++;
        if (gaddr.size() < 4 || dpc.size() < 3) begin
            errors++;
            $display("FAIL zl_count: got %0d grants %0d deliveries required >=4 and >=3",
                     gaddr.size(), dpc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gaddr[i] !== 32'(4 * i) || dpc[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL zl_order: idx %0d got fetch=%h deliver=%h required %h",
                             i, gaddr[i], dpc[i], 32'(4 * i));
                end
                checks++;
                if (gcyc[i+1] - gcyc[i] != 2) begin
                    errors++;
                    $display("FAIL zl_spacing: idx %0d got %0d cycles required 2", i, gcyc[i+1] - gcyc[i]);
                end
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        lat_rand = 1'b0; mem_lat = 0; gnt_pct = 100;
        do_reset();
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (ifid_valid === 1'b1 && ifid_pc == 32'h4) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_setup_timeout: pc 0x4 never reached IF/ID");
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (k == 0) begin
                checks++;
                if (!(last_req && last_gnt && last_addr == 32'h8)) begin
                    errors++;
                    $display("FAIL stall_issue8: got req=%b addr=%h required req=1 addr=00000008",
                             last_req, last_addr);
                end
            end
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
                errors++;
                $display("FAIL stall_ifid: got v=%b pc=%h required v=1 pc=00000004", ifid_valid, ifid_pc);
            end
            if (k >= 2) begin
                checks++;
                if (last_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_req_blocked: got %b required 0", last_req);
                end
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== mem_word(32'h8)) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h instr=%h required v=1 pc=00000008 instr=%h",
                     ifid_valid, ifid_pc, ifid_instr, mem_word(32'h8));
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (last_req !== 1'b1 || last_addr !== 32'hC) begin
            errors++;
            $display("FAIL stall_next_fetch: got req=%b addr=%h required req=1 addr=0000000c",
                     last_req, last_addr);
        end
    endtask

    task automatic test_flush_wait;
        bit ok;
        bit seen_req;
        lat_rand = 1'b0; mem_lat = 3; gnt_pct = 100;
        do_reset();
        wait_grant(32'h10, 60, ok);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        seen_req = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (!seen_req && last_req) begin
                seen_req = 1'b1;
                checks++;
                if (last_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL flushw_addr: got %h required 00000100", last_addr);
                end
            end
            if (ifid_valid === 1'b1) begin
                ok = 1'b1;
                checks++;
                if (ifid_pc !== 32'h100 || ifid_instr !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL flushw_deliver: got pc=%h instr=%h required pc=00000100 instr=%h",
                             ifid_pc, ifid_instr, mem_word(32'h100));
                end
                break;
            end
        end
        checks++;
        if (!ok || !seen_req) begin
            errors++;
            $display("FAIL flushw_timeout: got deliver=%b req=%b required 1/1", ok, seen_req);
        end
    endtask

    task automatic test_flush_rvalid;
        bit ok;
        lat_rand = 1'b0; mem_lat = 0; gnt_pct = 100;
        do_reset();
        wait_grant(32'h8, 20, ok);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (last_req !== 1'b1 || last_addr !== 32'h40) begin
            errors++;
            $display("FAIL flushr_next: got req=%b addr=%h required req=1 addr=00000040",
                     last_req, last_addr);
        end
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (ifid_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || ifid_pc !== 32'h40) begin
            errors++;
            $display("FAIL flushr_deliver: got v=%b pc=%h required v=1 pc=00000040", ok, ifid_pc);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        lat_rand = 1'b0; mem_lat = 0; gnt_pct = 100;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (ifid_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || ifid_pc !== 32'hFFFF_FFFC || ifid_pc_plus4 !== 32'h0 || ifid_instr !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_deliver: got v=%b pc=%h p4=%h required v=1 pc=fffffffc p4=00000000",
                     ok, ifid_pc, ifid_pc_plus4);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got req=%b addr=%h required req=1 addr=00000000", last_req, last_addr);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        lat_rand = 1'b0; mem_lat = 3; gnt_pct = 100;
        do_reset();
        wait_grant(32'h4, 30, ok);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_pc_plus4 !== 32'd0 || ifid_instr !== NOP_V || last_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b pc=%h p4=%h instr=%h req=%b required all reset values",
                     ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, last_req);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (bubble_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_bubble: got %0d required 0", bubble_count);
        end
`endif
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (last_req !== 1'b1 || last_addr !== RST_PC) begin
            errors++;
            $display("FAIL midreset_refetch: got req=%b addr=%h required req=1 addr=%h",
                     last_req, last_addr, RST_PC);
        end
    endtask

    task automatic test_random;
        logic        r, s, f;
        logic [31:0] rd;
        lat_rand = 1'b1; gnt_pct = 70;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            r  = ($urandom_range(199) != 0);
            s  = ($urandom_range(99) < 25);
            f  = r && ($urandom_range(99) < 4);
            rd = $urandom;
            step(r, s, f, rd);
        end
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        @(negedge clk);
        test_reset();
        test_zero_latency();
        test_stall();
        test_flush_wait();
        test_flush_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
